// File: rtl/core_pkg.sv
// Purpose: shared encodings for the Ludi-V writeback stage (result source, load funct3, FSM state).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_pkg;

  // Result source select carried down from decode.
  localparam logic [1:0] ALU_RESULT = 2'b00;
  localparam logic [1:0] MEM_TO_REG = 2'b01;
  localparam logic [1:0] PC_PLUS    = 2'b10;
  localparam logic [1:0] LUI_AUIPC  = 2'b11;

  // Load funct3 encodings (width in [1:0], unsigned in [2]).
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Writeback FSM: IDLE accepts instructions, WAIT_RESP parks on a load.
  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } wb_state_t;

endpackage

// File: rtl/load_extend.sv
// Purpose: select the addressed byte/halfword of an aligned read word and sign/zero-extend it.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   funct3  - load width/sign (unlisted encodings behave as a full-word load)
//   addr_lo - byte address bits [1:0]; bit 0 is ignored for halfwords
//   rdata   - aligned read word from data memory
//   data    - extended load result
module load_extend
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
  end

  always_comb begin
    data = rdata;
    case (funct3)
      LB:      data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LBU:     data = {{(XLEN-8){1'b0}}, byte_sel};
      LH:      data = {{(XLEN-16){half_sel[15]}}, half_sel};
      LHU:     data = {{(XLEN-16){1'b0}}, half_sel};
      LW:      data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/stage_writeback.sv
// Purpose: final Ludi-V pipeline stage; selects the result, extends load data, drives the regfile write port.
// Latency: 1 cycle for non-loads; loads retire 1 cycle after dmem_rvalid (timeout after RESP_TIMEOUT cycles).
// Backpressure: wb_stall holds upstream from the cycle a load is accepted until its response/timeout cycle.
//
// Ports:
//   clk, rst_n              - core clock, asynchronous active-low reset
//   flush                   - kill the instruction on mem_* (or the pending load while waiting)
//   mem_valid, mem_rd, mem_regfile_wr_enable, mem_result_src, mem_funct3,
//   mem_alu_result, mem_instr_addr_plus, mem_lui_auipc_value - retiring instruction from memory stage
//   dmem_rvalid, dmem_rdata - data-memory read response
//   wb_wr_addr, wb_wr_data, wb_regfile_wr_enable - registered regfile write port (strobe never for x0)
//   wb_stall                - hold upstream stages
//   wb_load_fault           - one-cycle pulse when a live load times out
//   wb_instret              - 64-bit retired-instruction count, only when WB_INSTRET_EN is defined
//
// Optional feature: define WB_INSTRET_EN to add the wb_instret counter and port.
module stage_writeback
  import core_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic            mem_regfile_wr_enable,
  input  logic [1:0]      mem_result_src,
  input  logic [2:0]      mem_funct3,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_instr_addr_plus,
  input  logic [XLEN-1:0] mem_lui_auipc_value,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [4:0]      wb_wr_addr,
  output logic [XLEN-1:0] wb_wr_data,
  output logic            wb_regfile_wr_enable,
  output logic            wb_stall,
  output logic            wb_load_fault
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]     wb_instret
`endif
);

  localparam int CW = $clog2(RESP_TIMEOUT + 1);

  wb_state_t       state;
  logic [CW-1:0]   wait_cnt;

  // Load context captured at acceptance; mem_* may change while we wait.
  logic [4:0]      cap_rd;
  logic            cap_we;
  logic [2:0]      cap_funct3;
  logic [1:0]      cap_addr_lo;
  logic            cap_killed;

  logic [XLEN-1:0] sel_data;
  logic [XLEN-1:0] ext_data;
  logic            accept;
  logic            accept_load;
  logic            accept_other;
  logic            killed_now;
  logic            resp_done;
  logic            resp_timeout;

  always_comb begin
    case (mem_result_src)
      PC_PLUS:   sel_data = mem_instr_addr_plus;
      LUI_AUIPC: sel_data = mem_lui_auipc_value;
      default:   sel_data = mem_alu_result;
    endcase
  end

  load_extend #(
    .XLEN (XLEN)
  ) u_load_extend (
    .funct3  (cap_funct3),
    .addr_lo (cap_addr_lo),
    .rdata   (dmem_rdata),
    .data    (ext_data)
  );

  always_comb begin
    accept       = (state == IDLE) && mem_valid && !flush;
    accept_load  = accept && (mem_result_src == MEM_TO_REG);
    accept_other = accept && (mem_result_src != MEM_TO_REG);
    // A flush in the same cycle as the response still kills the load.
    killed_now   = cap_killed || flush;
    resp_done    = (state == WAIT_RESP) && dmem_rvalid;
    // Response in the last counted cycle takes priority over the timeout.
    resp_timeout = (state == WAIT_RESP) && !dmem_rvalid &&
                   (wait_cnt == CW'(RESP_TIMEOUT - 1));
    // Stall is raised combinationally in the acceptance cycle so upstream holds immediately.
    wb_stall     = (state == WAIT_RESP) || accept_load;
  end

  // FSM and load capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cap_rd      <= '0;
      cap_we      <= 1'b0;
      cap_funct3  <= '0;
      cap_addr_lo <= '0;
      cap_killed  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_load) begin
            state       <= WAIT_RESP;
            wait_cnt    <= '0;
            cap_rd      <= mem_rd;
            cap_we      <= mem_regfile_wr_enable;
            cap_funct3  <= mem_funct3;
            cap_addr_lo <= mem_alu_result[1:0];
            cap_killed  <= 1'b0;
          end
        end
        WAIT_RESP: begin
          if (flush) begin
            cap_killed <= 1'b1;
          end
          if (resp_done || resp_timeout) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered regfile write port and fault pulse.
  // Address/data only update on a real retirement so they hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_wr_addr           <= '0;
      wb_wr_data           <= '0;
      wb_regfile_wr_enable <= 1'b0;
      wb_load_fault        <= 1'b0;
    end else begin
      wb_regfile_wr_enable <= 1'b0;
      wb_load_fault        <= 1'b0;
      if (accept_other) begin
        wb_wr_addr           <= mem_rd;
        wb_wr_data           <= sel_data;
        wb_regfile_wr_enable <= mem_regfile_wr_enable && (mem_rd != 5'd0);
      end else if (resp_done && !killed_now) begin
        wb_wr_addr           <= cap_rd;
        wb_wr_data           <= ext_data;
        wb_regfile_wr_enable <= cap_we && (cap_rd != 5'd0);
      end
      if (resp_timeout && !killed_now) begin
        wb_load_fault <= 1'b1;
      end
    end
  end

`ifdef WB_INSTRET_EN
  // Counts committed instructions: accepted non-loads and completed live loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_instret <= '0;
    end else if (accept_other || (resp_done && !killed_now)) begin
      wb_instret <= wb_instret + 64'd1;
    end
  end
`endif

endmodule

// File: doc/stage_writeback.md
Name: stage_writeback

Overview:
- Final pipeline stage of the Ludi-V core.
- Accepts retiring instructions from the memory stage and selects the result by result_src (ALU result, load data, PC+4, LUI/AUIPC value).
- Extracts and extends load data, then drives the register-file write port back into the decode stage.
- Waits on a variable-latency data-memory read response and stalls upstream while it waits.

Parameters:
- XLEN, 32, datapath width.
- RESP_TIMEOUT, 255, maximum cycles spent waiting for dmem_rvalid before the load is aborted.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill the instruction currently presented on the mem_* inputs
- mem_valid  in  1  a retiring instruction is present on the mem_* inputs
- mem_rd  in  5  destination register
- mem_regfile_wr_enable  in  1  instruction writes rd
- mem_result_src  in  2  00 ALU_RESULT, 01 MEM_TO_REG, 10 PC_PLUS, 11 LUI_AUIPC
- mem_funct3  in  3  load width/sign
- mem_alu_result  in  XLEN  ALU result; for loads, the byte address (bits [1:0] are used)
- mem_instr_addr_plus  in  XLEN  PC+4
- mem_lui_auipc_value  in  XLEN  LUI/AUIPC result
- dmem_rvalid  in  1  read response valid
- dmem_rdata  in  XLEN  read word (aligned)
- wb_wr_addr  out  5  register-file write address
- wb_wr_data  out  XLEN  register-file write data
- wb_regfile_wr_enable  out  1  register-file write strobe, one cycle per retired write
- wb_stall  out  1  hold upstream stages
- wb_load_fault  out  1  one-cycle pulse on load timeout

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs are 0.
  - FSM goes to IDLE.
  - Internal capture registers are cleared.
- FSM states: IDLE and WAIT_RESP.
- IDLE, mem_valid=1, flush=0:
  - result_src != MEM_TO_REG: the write is registered. Next cycle wb_wr_addr=mem_rd, wb_wr_data=selected value, wb_regfile_wr_enable=mem_regfile_wr_enable && (mem_rd != 0). Latency is 1 cycle.
  - result_src == MEM_TO_REG: capture rd, funct3 and addr[1:0], then go to WAIT_RESP. wb_stall is asserted combinationally in that same cycle.
- WAIT_RESP:
  - wb_stall=1.
  - On dmem_rvalid, form the extended data and register the write; it is visible the next cycle. Return to IDLE and drop wb_stall in that cycle.
  - If dmem_rvalid coincides with the last counted cycle, the response wins.
- Load extraction:
  - LB (000) / LBU (100): byte at addr[1:0], sign- or zero-extended.
  - LH (001) / LHU (101): halfword at addr[1], sign- or zero-extended; addr[0] is ignored.
  - LW (010): full word.
  - Any other funct3 is treated as LW.
- Timeout:
  - A counter counts cycles spent in WAIT_RESP.
  - At RESP_TIMEOUT cycles with no response, pulse wb_load_fault, perform no write, and return to IDLE.
- flush:
  - In IDLE it suppresses capture; the next cycle wb_regfile_wr_enable=0.
  - In WAIT_RESP it marks the pending load killed. The FSM still waits for the response or the timeout. The response is consumed but not written, and no fault is raised for a killed load.
- mem_valid=0: wb_regfile_wr_enable=0 the next cycle. wb_wr_addr and wb_wr_data hold their last values.
- wb_regfile_wr_enable is a single-cycle strobe and never asserts for rd=0.
- dmem_rvalid in IDLE is ignored.

Optional Feature:
- Macro WB_INSTRET_EN.
- When defined:
  - A 64-bit retired-instruction counter increments once per committed instruction. Committed means: accepted non-load with mem_valid && !flush, or a completed, non-killed load.
  - Exposed as the extra output wb_instret [63:0]; reset value 0; wraps modulo 2^64.
- When undefined: the counter and the port do not exist, and the remaining behaviour is identical.

Decomposition:
- Package core_pkg holds:
  - result_src localparams ALU_RESULT, MEM_TO_REG, PC_PLUS, LUI_AUIPC.
  - funct3 load encodings LB, LH, LW, LBU, LHU.
  - wb_state_t enum {IDLE, WAIT_RESP}.
- Sub-module load_extend: combinational byte/half select and extension (funct3, addr_lo, rdata -> data).

Test Plan:
- ALU op, rd=5, alu_result=0x1234 -> next cycle wb_wr_addr=5, wb_wr_data=0x1234, strobe=1 for exactly 1 cycle.
- LB, addr_lo=2, rdata=0x00800000, rvalid after 3 cycles -> wb_stall high for 4 cycles; wb_wr_data=0xFFFFFF80. Same case with LBU -> 0x00000080.
- LH, addr_lo=2, rdata=0x8001_0000 -> 0xFFFF8001. LHU -> 0x00008001. LW -> 0x80010000.
- JAL with rd=0, instr_addr_plus=0x104 -> no strobe. Same with rd=1 -> wb_wr_data=0x104.
- Load with flush asserted during WAIT_RESP, response arrives -> no write, wb_stall drops, no fault. Load with no rvalid for RESP_TIMEOUT cycles -> single wb_load_fault pulse, no write.
- rst_n asserted mid-WAIT_RESP -> outputs go to 0 immediately; a later rvalid is ignored. With WB_INSTRET_EN, 3 ALU ops plus 1 load -> wb_instret=4.
